csa_cpa_pipe: RTL and testbench
===============================

Name: csa_cpa_pipe

Overview:
- Two-stage pipelined carry-propagate adder that resolves the redundant sum/carry pair from the carry-save adder array into one binary result.
- Sits directly downstream of the carry-save reduction tree in the MAC datapath and feeds normalisation/rounding.
- The carry vector is weighted by 2: the block left-shifts it internally, and cin_i fills bit 0.
- Valid/ready handshake on both sides, with stall and synchronous flush.

Parameters:
- XLEN, 49, width of the sum/carry operands and of the result.
- LOW_W, 24, width of the low slice added in stage 1; the high slice (XLEN-LOW_W bits) is added in stage 2. Legal range 1..XLEN-1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; drops all in-flight data.
- in_valid_i  input  1  upstream has an operand pair.
- in_ready_o  output  1  block accepts an operand pair this cycle.
- sum_i  input  XLEN  sum vector from the carry-save stage.
- cy_i  input  XLEN  carry vector from the carry-save stage, unshifted.
- cin_i  input  1  carry-in, inserted at bit 0 of the shifted carry vector.
- out_valid_o  output  1  result_o/cout_o are valid.
- out_ready_i  input  1  downstream accepts the result.
- result_o  output  XLEN  resolved sum, mod 2^XLEN.
- cout_o  output  1  bit XLEN of the full addition.

Behaviour:
Reset and clocking:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: all valid flags 0, all data registers 0. Hence out_valid_o=0, result_o=0, cout_o=0, and in_ready_o=1.

Arithmetic:
- Define B = {cy_i[XLEN-2:0], cin_i}; cy_i[XLEN-1] is discarded by design.
- Full result F = sum_i + B, width XLEN+1. result_o = F[XLEN-1:0], cout_o = F[XLEN].

Stage 1 (on accept):
- Register lo = sum_i[LOW_W-1:0] + B[LOW_W-1:0], LOW_W+1 bits. Bit LOW_W is the mid carry c1.
- Register the high slices sum_i[XLEN-1:LOW_W] and B[XLEN-1:LOW_W] unmodified.
- Set v1=1.

Stage 2 (on advance):
- Compute hi = sum_hi + B_hi + c1, XLEN-LOW_W+1 bits.
- Register result = {hi[XLEN-LOW_W-1:0], lo[LOW_W-1:0]} and cout = hi[XLEN-LOW_W].
- Set v2=1.

Handshake:
- Latency: 2 cycles from accept to out_valid_o when there is no backpressure. Throughput is 1 per cycle.
- Stage ready rules: ready2 = !v2 | out_ready_i; ready1 = !v1 | ready2; in_ready_o = ready1. This is a combinational ready chain; no skid buffer.
- Accept occurs when in_valid_i & in_ready_o.
- Stage 1 moves to stage 2 when v1 & ready2.
- Output handshake completes when out_valid_o & out_ready_i.
- While out_valid_o=1 and out_ready_i=0: result_o and cout_o hold stable, and stage 1 holds if occupied.
- Simultaneous events in one cycle (stage 2 emitting, stage 1 advancing, new accept) are all legal; no bubble is inserted.
- When stage 1 advances and no new accept occurs, v1 clears.

Flush and reset mid-operation:
- flush_i=1 clears v1 and v2 at the next edge; data registers may keep stale values.
- in_ready_o is forced to 0 during a flush cycle; an in_valid_i present in that cycle is not accepted.
- flush_i takes precedence over every handshake in the same cycle.
- Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.

Datapath hygiene:
- Data registers load only on a stage advance; no enable toggling otherwise.
- No X propagates from idle inputs into out_valid_o.

Test Plan:
1. Reset, then sum_i=49'h1, cy_i=49'h1, cin_i=1, out_ready_i=1. Required: out_valid_o=1 exactly 2 cycles after accept, result_o=49'h4, cout_o=0.
2. Mid-carry ripple across the slice boundary: sum_i=49'h0_00FF_FFFF (low 24 bits all ones), cy_i=0, cin_i=1. Required: result_o=49'h0_0100_0000, cout_o=0. Then sum_i=all ones, cy_i=0, cin_i=1. Required: result_o=0, cout_o=1.
3. Discarded MSB: cy_i=49'h1_0000_0000_0000 (bit 48 only), sum_i=0, cin_i=0. Required: result_o=0, cout_o=0.
4. Backpressure: stream 4 back-to-back operands with out_ready_i=0 for 3 cycles. Required: in_ready_o drops to 0 once both stages are full; result_o holds the first result stable; all 4 results emerge in order with no loss or duplication after out_ready_i returns to 1.
5. Flush with both stages full and a new in_valid_i in the same cycle. Required: next cycle out_valid_o=0; the flushed operands never appear; the following accepted operand produces the correct result 2 cycles after its accept.
6. Assert rst_ni low asynchronously between clock edges while stages are full. Required: out_valid_o=0 and result_o=0 immediately; in_ready_o=1 after release. Also run 10k random sum/cy/cin with random out_ready_i stalls, checking against the reference model F = sum + {cy[47:0],cin}.

Source files
------------

// File: rtl/csa_cpa_pipe.sv
// Two-stage carry-propagate adder resolving a carry-save sum/carry pair into one binary result.
// Latency: 2 cycles from accept to out_valid_o, throughput one operand pair per cycle.
// Backpressure: combinational ready chain, no skid buffer; a stalled output holds both stages.
module csa_cpa_pipe #(
  parameter int XLEN  = 49,
  parameter int LOW_W = 24
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] sum_i,
  input  logic [XLEN-1:0] cy_i,
  input  logic            cin_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            cout_o
);

  localparam int HIGH_W = XLEN - LOW_W;

  // Carry vector carries weight 2: shift it up and let cin_i fill the vacated bit 0.
  // The carry MSB would land at bit XLEN and is dropped on purpose.
  logic [XLEN-1:0] b_vec;
  logic            unused_cy_msb;

  assign b_vec         = {cy_i[XLEN-2:0], cin_i};
  assign unused_cy_msb = cy_i[XLEN-1];

  // Pipeline state
  logic              v1;
  logic              v2;
  logic [LOW_W:0]    lo_q;
  logic [HIGH_W-1:0] sum_hi_q;
  logic [HIGH_W-1:0] b_hi_q;
  logic [XLEN-1:0]   result_q;
  logic              cout_q;

  // Handshake terms
  logic ready1;
  logic ready2;
  logic accept;
  logic adv1;
  logic emit;

  assign ready2      = !v2 | out_ready_i;
  assign ready1      = !v1 | ready2;
  // A flush cycle refuses new input so nothing slips in behind the flush.
  assign in_ready_o  = ready1 & !flush_i;
  assign accept      = in_valid_i & in_ready_o;
  assign adv1        = v1 & ready2 & !flush_i;
  assign emit        = v2 & out_ready_i;

  // Arithmetic for each stage
  logic [LOW_W:0]  lo_d;
  logic [HIGH_W:0] hi_d;

  assign lo_d = {1'b0, sum_i[LOW_W-1:0]} + {1'b0, b_vec[LOW_W-1:0]};
  assign hi_d = {1'b0, sum_hi_q} + {1'b0, b_hi_q} + (HIGH_W+1)'(lo_q[LOW_W]);

  // Valid flags: flush wins over every handshake; stage 1 refills in the same cycle it drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (flush_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (accept) begin
        v1 <= 1'b1;
      end else if (adv1) begin
        v1 <= 1'b0;
      end
      if (adv1) begin
        v2 <= 1'b1;
      end else if (emit) begin
        v2 <= 1'b0;
      end
    end
  end

  // Stage 1 data: low-slice sum with its mid carry, plus the untouched high slices.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q     <= '0;
      sum_hi_q <= '0;
      b_hi_q   <= '0;
    end else if (accept) begin
      lo_q     <= lo_d;
      sum_hi_q <= sum_i[XLEN-1:LOW_W];
      b_hi_q   <= b_vec[XLEN-1:LOW_W];
    end
  end

  // Stage 2 data: high-slice sum absorbs the mid carry and is joined with the low slice.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (adv1) begin
      result_q <= {hi_d[HIGH_W-1:0], lo_q[LOW_W-1:0]};
      cout_q   <= hi_d[HIGH_W];
    end
  end

  assign out_valid_o = v2;
  assign result_o    = result_q;
  assign cout_o      = cout_q;

endmodule

// File: tb/tb_csa_cpa_pipe.sv
// Bench for csa_cpa_pipe: directed corner cases, backpressure, flush, async reset, random stream.
// Expected results are queued at accept time and compared when the output handshake completes.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_csa_cpa_pipe;

  localparam int XLEN = 49;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] cy;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            cout;

  int              n_checks = 0;
  int              n_pass   = 0;
  logic [XLEN:0]   sb[$];
  logic [XLEN:0]   mon_exp;
  bit              stall_en;

  always #5 clk = ~clk;

  csa_cpa_pipe #(.XLEN(XLEN), .LOW_W(24)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sum_i       (sum),
    .cy_i        (cy),
    .cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .cout_o      (cout)
  );

  // Reference: plain full-width addition of sum and the shifted carry vector.
  function automatic logic [XLEN:0] model(input logic [XLEN-1:0] s, input logic [XLEN-1:0] c,
                                          input logic ci);
    logic [XLEN-1:0] b;
    b = {c[XLEN-2:0], ci};
    return {1'b0, s} + {1'b0, b};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair and hold it until accepted; queue its expected result.
  task automatic send(input logic [XLEN-1:0] s, input logic [XLEN-1:0] c, input logic ci,
                      input logic [XLEN:0] exp);
    bit done;
    done     = 1'b0;
    sum      = s;
    cy       = c;
    cin      = ci;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        sb.push_back(exp);
        done = 1'b1;
      end
    end
    if (!done) check_eq("send_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send into an empty pipe and confirm out_valid rises exactly two cycles after accept.
  task automatic send_lat(input string tag, input logic [XLEN-1:0] s, input logic [XLEN-1:0] c,
                          input logic ci, input logic [XLEN:0] exp);
    send(s, c, ci, exp);
    @(negedge clk);
    check_eq({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, {63'd0, out_valid}, 64'd1);
    sync();
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check_eq(tag, 64'(sb.size()), 64'd0);
    sync();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    sum       = '0;
    cy        = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    stall_en  = 1'b0;

    // Output monitor: every completed output handshake must match the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && !flush && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("spurious_out", {63'd0, out_valid}, 64'd0);
          end else begin
            mon_exp = sb.pop_front();
            check_eq("result", {15'd0, result}, {15'd0, mon_exp[XLEN-1:0]});
            check_eq("cout", {63'd0, cout}, {63'd0, mon_exp[XLEN]});
          end
        end
      end
    join_none

    // Reset state
    #12;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_result", {15'd0, result}, 64'd0);
    check_eq("rst_cout", {63'd0, cout}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    sync();

    // Basic add, mid-carry ripple, full overflow, discarded carry MSB
    send_lat("t1", 49'h1, 49'h1, 1'b1, 50'h4);
    send_lat("t2a", 49'h0_00FF_FFFF, 49'h0, 1'b1, 50'h0_0100_0000);
    send_lat("t2b", 49'h1_FFFF_FFFF_FFFF, 49'h0, 1'b1, {1'b1, 49'h0});
    send_lat("t3", 49'h0, 49'h1_0000_0000_0000, 1'b0, 50'h0);
    drain("directed_drain");

    // Backpressure: four back-to-back operands against a stalled output
    out_ready = 1'b0;
    fork
      begin
        send(49'd10, 49'd5, 1'b0, 50'd20);
        send(49'd100, 49'd0, 1'b1, 50'd101);
        send(49'd0, 49'd7, 1'b1, 50'd15);
        send(49'h1_0000_0000_0000, 49'h0_8000_0000_0000, 1'b0, {1'b1, 49'h0});
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("bp_result0", {15'd0, result}, 64'd20);
        @(negedge clk);
        check_eq("bp_hold", {15'd0, result}, 64'd20);
        check_eq("bp_valid", {63'd0, out_valid}, 64'd1);
        sync();
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Flush with both stages full and a new operand offered in the flush cycle
    out_ready = 1'b0;
    send(49'd1234, 49'd1, 1'b0, 50'd1236);
    send(49'd77, 49'd3, 1'b1, 50'd84);
    sum      = 49'd999;
    cy       = 49'd999;
    cin      = 1'b1;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd0);
    sync();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    sync();
    out_ready = 1'b1;
    send_lat("post_flush", 49'h0_00FF_FFFF, 49'h0_0000_0080_0000, 1'b0, 50'h0_01FF_FFFF);
    drain("flush_drain");

    // Asynchronous reset between clock edges with both stages full
    out_ready = 1'b0;
    send(49'd5, 49'd5, 1'b1, 50'd16);
    send(49'd6, 49'd6, 1'b1, 50'd19);
    check_eq("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("arst_result", {15'd0, result}, 64'd0);
    check_eq("arst_cout", {63'd0, cout}, 64'd0);
    sb.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    sync();
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

    // Random stream with random output stalls
    stall_en = 1'b1;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          logic [63:0]     r;
          logic [XLEN-1:0] rs;
          logic [XLEN-1:0] rc;
          logic            rci;
          r   = {$urandom, $urandom};
          rs  = r[XLEN-1:0];
          r   = {$urandom, $urandom};
          rc  = r[XLEN-1:0];
          rci = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) rs = '1;
          if ($urandom_range(0, 7) == 0) rc = '1;
          if ($urandom_range(0, 3) == 0) sync();
          send(rs, rc, rci, model(rs, rc, rci));
        end
        stall_en = 1'b0;
      end
      begin
        while (stall_en) begin
          sync();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
